// File: rtl/victim_cache_ctrl.sv
// Control for a 4-entry fully associative victim buffer: tag/valid/dirty/LRU
// bookkeeping, L1 lookup and evict handshakes, and dirty-line writeback to memory.
module victim_cache_ctrl #(
    parameter int WIDTH     = 256,
    parameter int TAG_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l1_lookup_req,
    input  logic [TAG_WIDTH-1:0] l1_lookup_tag,
    output logic                 l1_lookup_resp,
    output logic                 l1_lookup_hit,
    output logic                 l1_lookup_dirty,
    output logic [WIDTH-1:0]     l1_lookup_data,
    input  logic                 l1_evict_req,
    input  logic [TAG_WIDTH-1:0] l1_evict_tag,
    input  logic [WIDTH-1:0]     l1_evict_data,
    input  logic                 l1_evict_dirty,
    output logic                 l1_evict_done,
    output logic                 vic_load,
    output logic [1:0]           vic_index,
    output logic [WIDTH-1:0]     vic_wdata,
    input  logic [WIDTH-1:0]     vic_rdata,
    output logic                 mem_write,
    output logic [TAG_WIDTH+4:0] mem_address,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic                 mem_resp
);
    typedef enum logic [1:0] {IDLE, RESP, WRITEBACK, INSERT} state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  valid_q, valid_d, dirty_q, dirty_d;
    logic [3:0][TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [3:0][1:0]             age_q, age_d;
    logic                        hit_q, hit_d;
    logic [1:0]                  idx_q, idx_d;

    logic       lk_hit, ev_match, inv_found;
    logic [1:0] lk_idx, ev_idx, inv_idx, lru_idx, tgt;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        lk_hit    = 1'b0;
        lk_idx    = 2'd0;
        ev_match  = 1'b0;
        ev_idx    = 2'd0;
        inv_found = 1'b0;
        inv_idx   = 2'd0;
        lru_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == l1_lookup_tag) begin
                lk_hit = 1'b1;
                lk_idx = 2'(i);
            end
            if (valid_q[i] && tag_q[i] == l1_evict_tag) begin
                ev_match = 1'b1;
                ev_idx   = 2'(i);
            end
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = 2'(i);
            end
            if (age_q[i] == 2'd3) lru_idx = 2'(i);
        end
        tgt = ev_match ? ev_idx : (inv_found ? inv_idx : lru_idx);
    end

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        tag_d           = tag_q;
        age_d           = age_q;
        hit_d           = hit_q;
        idx_d           = idx_q;
        l1_lookup_resp  = 1'b0;
        l1_lookup_hit   = 1'b0;
        l1_lookup_dirty = 1'b0;
        l1_lookup_data  = '0;
        l1_evict_done   = 1'b0;
        vic_load        = 1'b0;
        vic_index       = 2'd0;
        vic_wdata       = '0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        case (state_q)
            IDLE: begin
                if (l1_lookup_req) begin
                    hit_d   = lk_hit;
                    idx_d   = lk_idx;
                    state_d = RESP;
                end else if (l1_evict_req) begin
                    idx_d   = tgt;
                    state_d = (valid_q[tgt] && dirty_q[tgt]) ? WRITEBACK : INSERT;
                end
            end
            RESP: begin
                l1_lookup_resp = 1'b1;
                if (hit_q) begin
                    l1_lookup_hit   = 1'b1;
                    l1_lookup_dirty = dirty_q[idx_q];
                    l1_lookup_data  = vic_rdata;
                    vic_index       = idx_q;
                    valid_d[idx_q]  = 1'b0;
                    dirty_d[idx_q]  = 1'b0;
                end
                state_d = IDLE;
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {tag_q[idx_q], 5'b0};
                mem_wdata   = vic_rdata;
                vic_index   = idx_q;
                if (mem_resp) state_d = INSERT;
            end
            INSERT: begin
                vic_load       = 1'b1;
                vic_index      = idx_q;
                vic_wdata      = l1_evict_data;
                valid_d[idx_q] = 1'b1;
                dirty_d[idx_q] = l1_evict_dirty;
                tag_d[idx_q]   = l1_evict_tag;
                l1_evict_done  = 1'b1;
                // Promote target to MRU; only younger entries age, keeping a permutation.
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) == idx_q)              age_d[i] = 2'd0;
                    else if (age_q[i] < age_q[idx_q]) age_d[i] = age_q[i] + 2'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            age_q   <= {2'd0, 2'd1, 2'd2, 2'd3};
            hit_q   <= 1'b0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            age_q   <= age_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end
endmodule
